kg_output_streamer: RTL and testbench

Key-generation output transmitter inside the `dilithium` core. After the keygen datapath finishes, it reads the packed result fields from the core's field storage and emits them as one word stream on `data_o` with a `valid_o`/`ready_o` handshake, in the segment order the host expects for the configured `HIGH_PERF`/`SEC_LEVEL`. It sustains one word per cycle under arbitrary backpressure.

---
 rtl/kg_output_streamer_pkg.sv | 53 +++++
 rtl/kg_output_streamer_if.sv | 41 ++++
 rtl/kg_output_streamer_skid_buf.sv | 60 ++++++
 rtl/kg_output_streamer.sv | 159 +++++++++++++++
 tb/tb_kg_output_streamer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kg_output_streamer_pkg.sv
// kg_output_streamer_pkg: segment ids, per-level segment sizes and the two
// host segment orders shared by the keygen output streamer.
package kg_output_streamer_pkg;

  typedef enum logic [2:0] {
    SEG_RHO = 3'd0,
    SEG_K   = 3'd1,
    SEG_S1  = 3'd2,
    SEG_S2  = 3'd3,
    SEG_T1  = 3'd4,
    SEG_T0  = 3'd5,
    SEG_TR  = 3'd6
  } kg_seg_t;

  localparam int KG_ORDER_MAX = 8;
  localparam int KG_ADDR_W    = 9;

  // High-performance order has seven segments; the eighth slot is never reached.
  localparam kg_seg_t KG_ORDER_HP [KG_ORDER_MAX] = '{
    SEG_RHO, SEG_K, SEG_S1, SEG_S2, SEG_T1, SEG_T0, SEG_TR, SEG_TR
  };

  // Compact order re-emits RHO ahead of T1.
  localparam kg_seg_t KG_ORDER_LP [KG_ORDER_MAX] = '{
    SEG_RHO, SEG_K, SEG_TR, SEG_S1, SEG_S2, SEG_T0, SEG_RHO, SEG_T1
  };

  // Packed byte size of a segment at a given Dilithium level.
  function automatic int kg_seg_bytes(input int level, input kg_seg_t seg);
    int bytes;
    case (seg)
      SEG_S1:  bytes = (level == 5) ? 672  : (level == 3) ? 640  : 384;
      SEG_S2:  bytes = (level == 2) ? 384  : 768;
      SEG_T1:  bytes = (level == 5) ? 2560 : (level == 3) ? 1920 : 1280;
      SEG_T0:  bytes = (level == 5) ? 3328 : (level == 3) ? 2496 : 1664;
      default: bytes = 32;
    endcase
    return bytes;
  endfunction

  function automatic int kg_seg_words(input int level, input int w, input kg_seg_t seg);
    return (kg_seg_bytes(level, seg) * 8) / w;
  endfunction

  function automatic int kg_order_len(input bit high_perf);
    return high_perf ? 7 : 8;
  endfunction

  function automatic kg_seg_t kg_order_seg(input bit high_perf, input logic [2:0] idx);
    return high_perf ? KG_ORDER_HP[idx] : KG_ORDER_LP[idx];
  endfunction

endpackage

// File: rtl/kg_output_streamer_if.sv
// kg_output_streamer_if: control, storage-read and output-stream signals of
// the keygen output streamer. master = streamer side, slave = core/host side.
// last_o exists only when KG_SEG_LAST_EN is defined.
interface kg_output_streamer_if #(
  parameter int W = 64
);
  import kg_output_streamer_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  kg_seg_t              rd_seg;
  logic [KG_ADDR_W-1:0] rd_addr;
  logic [W-1:0]         rd_data;
  logic                 valid_o;
  logic                 ready_o;
  logic [W-1:0]         data_o;
`ifdef KG_SEG_LAST_EN
  logic                 last_o;

  modport master (
    input  start, rd_data, ready_o,
    output busy, done, rd_en, rd_seg, rd_addr, valid_o, data_o, last_o
  );
  modport slave (
    output start, rd_data, ready_o,
    input  busy, done, rd_en, rd_seg, rd_addr, valid_o, data_o, last_o
  );
`else
  modport master (
    input  start, rd_data, ready_o,
    output busy, done, rd_en, rd_seg, rd_addr, valid_o, data_o
  );
  modport slave (
    output start, rd_data, ready_o,
    input  busy, done, rd_en, rd_seg, rd_addr, valid_o, data_o
  );
`endif

endinterface

// File: rtl/kg_output_streamer_skid_buf.sv
// kg_skid_buf: 2-entry fall-through valid/ready buffer. When empty, the
// arriving word is presented directly; otherwise the head entry is. Output
// data is zero whenever nothing is valid.
module kg_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data,
  input  logic         i_rdy,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic [1:0]   r_cnt;

  logic         w_bypass;
  logic         w_push;
  logic         w_pop_mem;
  logic         w_wr_ptr;

  assign o_vld     = (r_cnt != 2'd0) || i_vld;
  assign o_cnt     = r_cnt;
  assign w_bypass  = (r_cnt == 2'd0) && i_vld && i_rdy;
  assign w_push    = i_vld && !w_bypass;
  assign w_pop_mem = (r_cnt != 2'd0) && i_rdy;
  assign w_wr_ptr  = r_head ^ r_cnt[0];

  // Present the head entry, else the word arriving this cycle, else zero.
  always_comb begin
    o_data = '0;
    if (r_cnt != 2'd0)
      o_data = r_mem[r_head];
    else if (i_vld)
      o_data = i_data;
  end

  // Occupancy and head pointer; the caller guarantees no push when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_head <= 1'b0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop_mem};
      if (w_pop_mem)
        r_head <= ~r_head;
    end
  end

  // Storage entries carry data only; their contents matter only while counted.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[w_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/kg_output_streamer.sv
// kg_output_streamer: after keygen, reads the packed result segments from
// field storage in host order and streams them with valid/ready.
// Optional feature macro: KG_SEG_LAST_EN adds last_o marking the final word
// of every segment.
module kg_output_streamer
  import kg_output_streamer_pkg::*;
#(
  parameter int W         = 64,
  parameter int SEC_LEVEL = 2,
  parameter bit HIGH_PERF = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  kg_output_streamer_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] ORDER_LAST = 3'(kg_order_len(HIGH_PERF) - 1);

  localparam logic [KG_ADDR_W-1:0] LAST_RHO = KG_ADDR_W'(kg_seg_words(SEC_LEVEL, W, SEG_RHO) - 1);
  localparam logic [KG_ADDR_W-1:0] LAST_K   = KG_ADDR_W'(kg_seg_words(SEC_LEVEL, W, SEG_K) - 1);
  localparam logic [KG_ADDR_W-1:0] LAST_S1  = KG_ADDR_W'(kg_seg_words(SEC_LEVEL, W, SEG_S1) - 1);
  localparam logic [KG_ADDR_W-1:0] LAST_S2  = KG_ADDR_W'(kg_seg_words(SEC_LEVEL, W, SEG_S2) - 1);
  localparam logic [KG_ADDR_W-1:0] LAST_T1  = KG_ADDR_W'(kg_seg_words(SEC_LEVEL, W, SEG_T1) - 1);
  localparam logic [KG_ADDR_W-1:0] LAST_T0  = KG_ADDR_W'(kg_seg_words(SEC_LEVEL, W, SEG_T0) - 1);
  localparam logic [KG_ADDR_W-1:0] LAST_TR  = KG_ADDR_W'(kg_seg_words(SEC_LEVEL, W, SEG_TR) - 1);

`ifdef KG_SEG_LAST_EN
  localparam int BUF_W = W + 1;
`else
  localparam int BUF_W = W;
`endif

  logic [1:0]           r_state;
  logic [2:0]           r_ord_idx;
  logic [KG_ADDR_W-1:0] r_addr;
  logic                 r_vld_p1;

  kg_seg_t              w_seg;
  logic [KG_ADDR_W-1:0] w_seg_last;
  logic                 w_addr_wrap;
  logic                 w_room;
  logic                 w_rd_en;
  logic [1:0]           w_buf_cnt;
  logic                 w_buf_vld;
  logic [BUF_W-1:0]     w_buf_in;
  logic [BUF_W-1:0]     w_buf_out;
  logic                 w_pop;
  logic [2:0]           w_remaining;
  logic                 w_drained;

  // Segment currently being read and the index of its final word.
  always_comb begin
    w_seg      = kg_order_seg(HIGH_PERF, r_ord_idx);
    w_seg_last = LAST_RHO;
    case (w_seg)
      SEG_K:   w_seg_last = LAST_K;
      SEG_S1:  w_seg_last = LAST_S1;
      SEG_S2:  w_seg_last = LAST_S2;
      SEG_T1:  w_seg_last = LAST_T1;
      SEG_T0:  w_seg_last = LAST_T0;
      SEG_TR:  w_seg_last = LAST_TR;
      default: w_seg_last = LAST_RHO;
    endcase
  end

  // Read only if the buffer can hold the word in flight plus this new one.
  // Deliberately independent of ready_o so valid_o never depends on it.
  assign w_addr_wrap = (r_addr == w_seg_last);
  assign w_room      = (w_buf_cnt == 2'd0) || ((w_buf_cnt == 2'd1) && !r_vld_p1);
  assign w_rd_en     = (r_state == ST_READ) && w_room;

  // Words still owed downstream; drained once this cycle's transfer takes the last.
  assign w_pop       = w_buf_vld && bus.ready_o;
  assign w_remaining = {1'b0, w_buf_cnt} + {2'b00, r_vld_p1};
  assign w_drained   = (w_remaining == {2'b00, w_pop});

  // Dump sequencing: IDLE -> READ -> DRAIN -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.start) r_state <= ST_READ;
        ST_READ:  if (w_rd_en && w_addr_wrap && (r_ord_idx == ORDER_LAST)) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_drained) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Order index and word address; both return to zero after the final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ord_idx <= 3'd0;
      r_addr    <= '0;
    end else if (w_rd_en) begin
      if (w_addr_wrap) begin
        r_addr    <= '0;
        r_ord_idx <= (r_ord_idx == ORDER_LAST) ? 3'd0 : r_ord_idx + 3'd1;
      end else begin
        r_addr <= r_addr + KG_ADDR_W'(1);
      end
    end
  end

  // Stage p0 -> p1: storage read issued, data returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_vld_p1 <= 1'b0;
    else
      r_vld_p1 <= w_rd_en;
  end

`ifdef KG_SEG_LAST_EN
  logic r_last_p1;

  // Segment-boundary flag travels with the in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_p1 <= 1'b0;
    else
      r_last_p1 <= w_rd_en && w_addr_wrap;
  end

  assign w_buf_in    = {r_last_p1, bus.rd_data};
  assign bus.last_o  = w_buf_out[W];
`else
  assign w_buf_in    = bus.rd_data;
`endif

  // Stage p1 -> output: returned data enters the skid buffer.
  kg_skid_buf #(
    .W (BUF_W)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (r_vld_p1),
    .i_data (w_buf_in),
    .o_vld  (w_buf_vld),
    .o_data (w_buf_out),
    .i_rdy  (bus.ready_o),
    .o_cnt  (w_buf_cnt)
  );

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.rd_en   = w_rd_en;
  assign bus.rd_seg  = w_seg;
  assign bus.rd_addr = r_addr;
  assign bus.valid_o = w_buf_vld;
  assign bus.data_o  = w_buf_out[W-1:0];

endmodule

// File: tb/tb_kg_output_streamer.sv
// tb_kg_output_streamer: drives L2 streamers in both segment orders (plus an
// L3 instance when KG_SEG_LAST_EN is defined) against a reference word list
// built from segment sizes and host order.
`timescale 1ns/1ps
module tb_kg_output_streamer;

  localparam int W   = 64;
  localparam int LVL = 2;
`ifdef KG_SEG_LAST_EN
  localparam int NDUT = 3;
`else
  localparam int NDUT = 2;
`endif

  typedef struct {
    int dut;
    int duty;
    int restart_at;
    int exp_words;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic         r_start [NDUT];
  logic         r_ready [NDUT];
  logic         m_busy  [NDUT];
  logic         m_done  [NDUT];
  logic         m_rd_en [NDUT];
  logic         m_valid [NDUT];
  logic [2:0]   m_seg   [NDUT];
  logic [8:0]   m_addr  [NDUT];
  logic [W-1:0] m_data  [NDUT];
`ifdef KG_SEG_LAST_EN
  logic         m_last  [NDUT];
`endif

  logic [W-1:0] exp_q[$];
  bit           exp_last_q[$];
  int           last_pos[$];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    kg_output_streamer_if #(.W(W)) bus ();

    assign bus.start   = r_start[g];
    assign bus.ready_o = r_ready[g];
    assign m_busy[g]   = bus.busy;
    assign m_done[g]   = bus.done;
    assign m_rd_en[g]  = bus.rd_en;
    assign m_valid[g]  = bus.valid_o;
    assign m_seg[g]    = bus.rd_seg;
    assign m_addr[g]   = bus.rd_addr;
    assign m_data[g]   = bus.data_o;
`ifdef KG_SEG_LAST_EN
    assign m_last[g]   = bus.last_o;
`endif

    // Field storage: word = {seg, addr}, one cycle latency, garbage when idle.
    always @(posedge clk) begin
      if (bus.rd_en)
        bus.rd_data <= W'({bus.rd_seg, bus.rd_addr});
      else
        bus.rd_data <= W'({$urandom(), $urandom()});
    end

    kg_output_streamer #(
      .W         (W),
      .SEC_LEVEL ((g == 2) ? 3 : LVL),
      .HIGH_PERF (g != 1)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int lvl_of(input int idx);
    return (idx == 2) ? 3 : LVL;
  endfunction

  // Segment ids: 0 RHO, 1 K, 2 S1, 3 S2, 4 T1, 5 T0, 6 TR.
  function automatic int seg_words(input int lvl, input int seg);
    int bytes;
    case (seg)
      2:       bytes = (lvl == 2) ? 384  : (lvl == 3) ? 640  : 672;
      3:       bytes = (lvl == 2) ? 384  : 768;
      4:       bytes = (lvl == 2) ? 1280 : (lvl == 3) ? 1920 : 2560;
      5:       bytes = (lvl == 2) ? 1664 : (lvl == 3) ? 2496 : 3328;
      default: bytes = 32;
    endcase
    return bytes * 8 / W;
  endfunction

  task automatic build_model(input int idx);
    int ord[$];
    int n;
    exp_q.delete();
    exp_last_q.delete();
    if (idx == 1) ord = '{0, 1, 6, 2, 3, 5, 0, 4};
    else          ord = '{0, 1, 2, 3, 4, 5, 6};
    foreach (ord[s]) begin
      n = seg_words(lvl_of(idx), ord[s]);
      for (int a = 0; a < n; a++) begin
        exp_q.push_back(W'({3'(ord[s]), 9'(a)}));
        exp_last_q.push_back(a == n - 1);
      end
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    check($sformatf("%s busy[%0d]", tag, i),    m_busy[i],  0);
    check($sformatf("%s done[%0d]", tag, i),    m_done[i],  0);
    check($sformatf("%s rd_en[%0d]", tag, i),   m_rd_en[i], 0);
    check($sformatf("%s rd_seg[%0d]", tag, i),  m_seg[i],   0);
    check($sformatf("%s rd_addr[%0d]", tag, i), m_addr[i],  0);
    check($sformatf("%s valid[%0d]", tag, i),   m_valid[i], 0);
    check($sformatf("%s data[%0d]", tag, i),    m_data[i],  0);
`ifdef KG_SEG_LAST_EN
    check($sformatf("%s last[%0d]", tag, i),    m_last[i],  0);
`endif
  endtask

  task automatic run_dump(input int idx, input int duty, input int restart_at,
                          input int exp_words, input int exp_done);
    int c = 0;
    int n_xfer = 0;
    int n_done = 0;
    int done_c = -1;
    bit prev_stall = 0;
    logic [W-1:0] prev_data = '0;
`ifdef KG_SEG_LAST_EN
    bit prev_last = 0;
`endif
    build_model(idx);
    last_pos.delete();
    @(negedge clk);
    r_start[idx] = 1'b1;
    while (c < 5000 && (done_c < 0 || c < done_c + 3)) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      r_start[idx] = (c == restart_at);
      r_ready[idx] = ($urandom_range(99) < duty);
      if (c == 1) begin
        check($sformatf("rd_en@1 dut%0d", idx), m_rd_en[idx], 1);
        check($sformatf("busy@1 dut%0d", idx),  m_busy[idx],  1);
        check($sformatf("valid@1 dut%0d", idx), m_valid[idx], 0);
      end
      if (c == 2)
        check($sformatf("valid@2 dut%0d", idx), m_valid[idx], 1);
      if (prev_stall) begin
        check($sformatf("stall valid c%0d", c), m_valid[idx], 1);
        check($sformatf("stall data c%0d", c),  m_data[idx],  prev_data);
`ifdef KG_SEG_LAST_EN
        check($sformatf("stall last c%0d", c),  m_last[idx],  prev_last);
`endif
      end
      if (m_valid[idx] && r_ready[idx]) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check($sformatf("extra word %0d", n_xfer), m_data[idx], {W{1'bx}});
        end else begin
          check($sformatf("word %0d dut%0d", n_xfer - 1, idx), m_data[idx], exp_q.pop_front());
`ifdef KG_SEG_LAST_EN
          check($sformatf("last %0d dut%0d", n_xfer - 1, idx), m_last[idx], exp_last_q.pop_front());
          if (m_last[idx]) last_pos.push_back(n_xfer - 1);
`endif
        end
      end
      if (m_done[idx]) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      prev_stall = m_valid[idx] && !r_ready[idx];
      prev_data  = m_data[idx];
`ifdef KG_SEG_LAST_EN
      prev_last  = m_last[idx];
`endif
    end
    check($sformatf("done seen dut%0d", idx),   done_c >= 0, 1);
    check($sformatf("word count dut%0d", idx),  n_xfer, exp_words);
    check($sformatf("words left dut%0d", idx),  exp_q.size(), 0);
    check($sformatf("done pulses dut%0d", idx), n_done, 1);
    if (exp_done >= 0)
      check($sformatf("done cycle dut%0d", idx), done_c, exp_done);
    check($sformatf("busy after dut%0d", idx),  m_busy[idx],  0);
    check($sformatf("valid after dut%0d", idx), m_valid[idx], 0);
  endtask

  initial begin
    vec_t vecs[$];
    int   n;
    int   dn;
    int   want_last[$];

    for (int i = 0; i < NDUT; i++) begin
      r_start[i] = 1'b0;
      r_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) check_idle(i, "reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vecs.push_back('{0, 100, -1, 476, 478});
    vecs.push_back('{1, 100, -1, 480, 482});
    vecs.push_back('{0,  30, -1, 476,  -1});
    vecs.push_back('{1,  30, -1, 480,  -1});
    vecs.push_back('{0, 100, 50, 476, 478});
    vecs.push_back('{1,  60, 50, 480,  -1});
`ifdef KG_SEG_LAST_EN
    vecs.push_back('{2, 100, -1, 740, 742});
`endif
    foreach (vecs[i])
      run_dump(vecs[i].dut, vecs[i].duty, vecs[i].restart_at, vecs[i].exp_words, vecs[i].exp_done);

`ifdef KG_SEG_LAST_EN
    want_last = '{3, 7, 87, 183, 423, 735, 739};
    check("last_o count L3", last_pos.size(), want_last.size());
    foreach (want_last[i])
      if (i < last_pos.size())
        check($sformatf("last_o pos %0d", i), last_pos[i], want_last[i]);
`endif

    // Abort a dump with reset at word 100, then dump again.
    n  = 0;
    dn = 0;
    @(negedge clk);
    r_ready[0] = 1'b1;
    r_start[0] = 1'b1;
    @(negedge clk);
    r_start[0] = 1'b0;
    for (int c = 0; c < 2000 && n < 100; c++) begin
      if (m_valid[0] && r_ready[0]) n++;
      if (m_done[0]) dn++;
      if (n < 100) @(negedge clk);
    end
    check("abort reached word 100", n, 100);
    check("abort busy before reset", m_busy[0], 1);
    rst_n = 1'b0;
    #1;
    check_idle(0, "async reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle(0, $sformatf("in reset c%0d", c));
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_done[0]) dn++;
    end
    check("no done for aborted dump", dn, 0);
    check_idle(0, "after abort");
    run_dump(0, 100, -1, 476, 478);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
